i2c_adc_target: RTL

- I2C target (slave) that answers the on-board ADC master as if it were a PCF8591-class converter.
- Accepts a control-byte write and serves 8-bit sample bytes on reads.
- Sits on the same sda/scl pair as the master. Used for loopback bring-up and for board-level emulation of the converter.
- Oversamples the bus with the system clock. Never drives SCL (no clock stretching).

---
 rtl/i2c_adc_target_if.sv | 24 ++
 rtl/i2c_adc_target.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_adc_target_if.sv
// Application-side bundle of the I2C ADC-emulating target: sample source and control-byte sink.
interface i2c_adc_target_if;
  logic [7:0] adc_data;
  logic       sample_req;
  logic [7:0] ctrl;
  logic       ctrl_valid;
  logic       busy;

  modport slave (
    input  adc_data,
    output sample_req,
    output ctrl,
    output ctrl_valid,
    output busy
  );

  modport master (
    output adc_data,
    input  sample_req,
    input  ctrl,
    input  ctrl_valid,
    input  busy
  );
endinterface

// File: rtl/i2c_adc_target.sv
// I2C target emulating a PCF8591-class ADC: accepts control-byte writes, serves adc_data on reads.
// Bus is oversampled by clk; SCL is never driven (no clock stretching).
module i2c_adc_target #(
  parameter logic [6:0]  ADDR        = 7'h48,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            scl,
  inout  wire             sda,
  i2c_adc_target_if.slave app
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_q, sda_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise_c, scl_fall_c, sda_rise_c, sda_fall_c;
  logic                   start_c, stop_c;
  logic [7:0]             rx_next_c;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       rx_sr;
  logic [6:0]       tx_sr;
  logic             rw;
  logic             ack_phase;
  logic             sda_oe;
  logic [7:0]       ctrl_q;
  logic             ctrl_valid_q;
  logic             sample_req_q;
  logic             busy_q;

  // Synchronisers idle at 1 so reset release never fabricates an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign scl_rise_c = scl_s & ~scl_q;
  assign scl_fall_c = ~scl_s & scl_q;
  assign sda_rise_c = sda_s & ~sda_q;
  assign sda_fall_c = ~sda_s & sda_q;
  assign start_c    = sda_fall_c & scl_s;
  assign stop_c     = sda_rise_c & scl_s;
  assign rx_next_c  = {rx_sr[6:0], sda_s};

  // Protocol FSM; START/STOP take priority over any bit activity in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      bit_cnt      <= '0;
      rx_sr        <= '0;
      tx_sr        <= '0;
      rw           <= 1'b0;
      ack_phase    <= 1'b0;
      sda_oe       <= 1'b0;
      ctrl_q       <= '0;
      ctrl_valid_q <= 1'b0;
      sample_req_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      ctrl_valid_q <= 1'b0;
      sample_req_q <= 1'b0;
      if (stop_c) begin
        state     <= S_IDLE;
        sda_oe    <= 1'b0;
        busy_q    <= 1'b0;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
      end else if (start_c) begin
        state     <= S_ADDR;
        sda_oe    <= 1'b0;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
      end else begin
        case (state)
          S_IDLE: ;
          S_ADDR: if (scl_rise_c) begin
            rx_sr   <= rx_next_c;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(7)) begin
              if (rx_next_c[7:1] == ADDR) begin
                state  <= S_ADDR_ACK;
                busy_q <= 1'b1;
                rw     <= rx_next_c[0];
              end else begin
                state  <= S_IDLE;
                busy_q <= 1'b0;
              end
            end
          end
          S_ADDR_ACK: if (scl_fall_c) begin
            if (!ack_phase) begin
              sda_oe    <= 1'b1;
              ack_phase <= 1'b1;
            end else begin
              ack_phase <= 1'b0;
              bit_cnt   <= '0;
              if (rw) begin
                tx_sr        <= app.adc_data[6:0];
                sample_req_q <= 1'b1;
                sda_oe       <= ~app.adc_data[7];
                state        <= S_RD_DATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= S_WR_DATA;
              end
            end
          end
          S_WR_DATA: if (scl_rise_c) begin
            rx_sr   <= rx_next_c;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(7)) state <= S_WR_ACK;
          end
          S_WR_ACK: if (scl_fall_c) begin
            if (!ack_phase) begin
              sda_oe       <= 1'b1;
              ctrl_q       <= rx_sr;
              ctrl_valid_q <= 1'b1;
              ack_phase    <= 1'b1;
            end else begin
              sda_oe    <= 1'b0;
              ack_phase <= 1'b0;
              bit_cnt   <= '0;
              state     <= S_WR_DATA;
            end
          end
          // A 1 bit is sent by releasing the line
          S_RD_DATA: if (scl_fall_c) begin
            if (bit_cnt == CNT_W'(7)) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= S_RD_ACK;
            end else begin
              sda_oe  <= ~tx_sr[6];
              tx_sr   <= {tx_sr[5:0], 1'b0};
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          S_RD_ACK: begin
            if (scl_rise_c) begin
              if (sda_s) begin
                state  <= S_IDLE;
                busy_q <= 1'b0;
                sda_oe <= 1'b0;
              end else begin
                ack_phase <= 1'b1;
              end
            end else if (scl_fall_c && ack_phase) begin
              ack_phase    <= 1'b0;
              tx_sr        <= app.adc_data[6:0];
              sample_req_q <= 1'b1;
              sda_oe       <= ~app.adc_data[7];
              bit_cnt      <= '0;
              state        <= S_RD_DATA;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign sda            = sda_oe ? 1'b0 : 1'bz;
  assign app.ctrl       = ctrl_q;
  assign app.ctrl_valid = ctrl_valid_q;
  assign app.sample_req = sample_req_q;
  assign app.busy       = busy_q;

endmodule
